// File: rtl/input_capture_axil_slave.sv
// AXI4-Lite register bank over synchronized, debounced, edge-latched inputs with a level interrupt.
// Latency: AW/W accept 1 cycle after both valid, B 1 cycle later; AR accept 1 cycle, R 1 cycle later.
// Backpressure: BVALID/RVALID held until BREADY/RREADY; no new write/read accepted while a response is pending.
module input_capture_axil_slave #(
    parameter int NUM_INPUTS         = 8,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int DEBOUNCE_RESET     = 100000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [NUM_INPUTS-1:0]           btn_in,
    output logic                            irq
);

    localparam logic [19:0] DEB_RST = 20'(DEBOUNCE_RESET);

    logic [31:0]           ctrl;
    logic [19:0]           deb;
    logic [NUM_INPUTS-1:0] evt;
    logic [NUM_INPUTS-1:0] sync1, sync2, level, level_d;
    logic [19:0]           cnt [NUM_INPUTS];

    logic                  aw_start, wr_en, rd_en;
    logic [1:0]            wr_idx, rd_idx;
    logic [31:0]           wmask, rd_mux;
    logic [NUM_INPUTS-1:0] evt_clr, rise;

    // Protection bits and sub-word address bits carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_start = S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY;
    assign wr_en    = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en    = S_AXI_ARREADY & S_AXI_ARVALID;
    assign wr_idx   = S_AXI_AWADDR[3:2];
    assign rd_idx   = S_AXI_ARADDR[3:2];
    assign wmask    = {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}}, {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign evt_clr  = (wr_en && wr_idx == 2'd3) ? (S_AXI_WDATA[NUM_INPUTS-1:0] & wmask[NUM_INPUTS-1:0]) : '0;
    assign rise     = level & ~level_d & {NUM_INPUTS{ctrl[0]}};

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;

    // Write channel: single-cycle AW/W ready pulse once both are valid, then hold B until taken.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
        end else begin
            S_AXI_AWREADY <= aw_start;
            S_AXI_WREADY  <= aw_start;
            if (wr_en)
                S_AXI_BVALID <= 1'b1;
            else if (S_AXI_BREADY)
                S_AXI_BVALID <= 1'b0;
        end
    end

    // Register file: byte-strobed CTRL/DEBOUNCE, event set wins over a same-cycle W1C, registered irq.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl <= '0;
            deb  <= DEB_RST;
            evt  <= '0;
            irq  <= 1'b0;
        end else begin
            if (wr_en && wr_idx == 2'd0)
                ctrl <= (ctrl & ~wmask) | (S_AXI_WDATA & wmask);
            if (wr_en && wr_idx == 2'd1)
                deb <= (deb & ~wmask[19:0]) | (S_AXI_WDATA[19:0] & wmask[19:0]);
            evt <= (evt & ~evt_clr) | rise;
            irq <= ctrl[0] & ctrl[1] & (|evt);
        end
    end

    // Read data mux; unimplemented bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            2'd0:    rd_mux = ctrl;
            2'd1:    rd_mux[19:0] = deb;
            2'd2:    rd_mux[NUM_INPUTS-1:0] = level;
            default: rd_mux[NUM_INPUTS-1:0] = evt;
        endcase
    end

    // Read channel: AR ready pulse, data captured on the accept edge and held until taken.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
            if (rd_en) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Per-pin 2-FF synchronizer and mismatch counter; level flips after DEBOUNCE+1 mismatched cycles.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            for (int i = 0; i < NUM_INPUTS; i++)
                cnt[i] <= '0;
        end else begin
            sync1   <= btn_in;
            sync2   <= sync1;
            level_d <= level;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (sync2[i] != level[i]) begin
                    if (cnt[i] == deb) begin
                        level[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 20'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

endmodule
